// File: rtl/instr_encoder_loader_if.sv
// Symbolic instruction-field handshake into the IMEM loader.
// Master offers fields with In_valid; the loader answers with In_ready.
interface instr_encoder_loader_if;
    logic        In_valid;
    logic        In_ready;
    logic [3:0]  Kind;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [15:0] Imm;
    logic [25:0] Target;

    modport master (
        output In_valid, Kind, Rs, Rt, Rd, Imm, Target,
        input  In_ready
    );

    modport slave (
        input  In_valid, Kind, Rs, Rt, Rd, Imm, Target,
        output In_ready
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Boot loader: encodes symbolic MIPS-subset fields into 32-bit words
// and writes them sequentially into IMEM through one write port.
module instr_encoder_loader #(
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic                    Clk,
    input  logic                    Clrn,
    input  logic                    Start,
    instr_encoder_loader_if.slave   in_if,
    output logic                    Mem_we,
    output logic [AW-1:0]           Mem_addr,
    output logic [31:0]             Mem_wdata,
    output logic [AW:0]             Count,
    output logic                    Full,
    output logic                    Err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        WR   = 2'd2
    } state_t;

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [3:0]    K_ILL   = 4'd15;

    state_t      state_q, state_d;
    logic [3:0]  kind_q;
    logic [4:0]  rs_q, rt_q, rd_q;
    logic [15:0] imm_q;
    logic [25:0] tgt_q;
    logic        accept;
    logic [AW:0] count_inc;

    function automatic logic [31:0] encode(
        input logic [3:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] tgt
    );
        logic [31:0] w;
        w = 32'd0;
        unique case (kind)
            4'd0:  w = {6'b000000, rs, rt, rd, 5'd0, 6'b100001};
            4'd1:  w = {6'b000000, rs, rt, rd, 5'd0, 6'b100011};
            4'd2:  w = {6'b000000, rs, rt, rd, 5'd0, 6'b100100};
            4'd3:  w = {6'b000000, rs, rt, rd, 5'd0, 6'b100101};
            4'd4:  w = {6'b000000, rs, 15'd0, 6'b001000};
            4'd5:  w = {6'b001000, rs, rt, imm};
            4'd6:  w = {6'b001100, rs, rt, imm};
            4'd7:  w = {6'b001101, rs, rt, imm};
            4'd8:  w = {6'b100011, rs, rt, imm};
            4'd9:  w = {6'b101011, rs, rt, imm};
            4'd10: w = {6'b000100, rs, rt, imm};
            4'd11: w = {6'b000101, rs, rt, imm};
            4'd12: w = {6'b000010, tgt};
            4'd13: w = {6'b001111, 5'd0, rt, imm};
            4'd14: w = {6'b000011, tgt};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // Ready is masked by Clrn so it reads low while reset is held.
    assign in_if.In_ready = Clrn & (state_q == IDLE) & ~Full;
    assign accept         = in_if.In_valid & in_if.In_ready & ~Start;
    assign Mem_we         = (state_q == WR) & ~Start;
    assign count_inc      = Count + CNT_ONE;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (Start) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (accept) state_d = ENC;
                ENC:     state_d = (kind_q == K_ILL) ? IDLE : WR;
                WR:      state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            kind_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            tgt_q     <= '0;
            Mem_addr  <= '0;
            Mem_wdata <= '0;
            Count     <= '0;
            Full      <= 1'b0;
            Err       <= 1'b0;
        end else if (Start) begin
            Mem_addr <= '0;
            Count    <= '0;
            Full     <= 1'b0;
            Err      <= 1'b0;
        end else begin
            if (accept) begin
                kind_q <= in_if.Kind;
                rs_q   <= in_if.Rs;
                rt_q   <= in_if.Rt;
                rd_q   <= in_if.Rd;
                imm_q  <= in_if.Imm;
                tgt_q  <= in_if.Target;
            end
            if (state_q == ENC) begin
                if (kind_q == K_ILL) Err <= 1'b1;
                else Mem_wdata <= encode(kind_q, rs_q, rt_q,
                                         rd_q, imm_q, tgt_q);
            end
            if (state_q == WR) begin
                Mem_addr <= Mem_addr + ADR_ONE;
                Count    <= count_inc;
                Full     <= (count_inc == DEPTH_C);
            end
        end
    end

endmodule
